// File: rtl/bresolve_if.sv
// -----------------------------------------------------------------------------
// bresolve_if -- bus bundle between execute, bresolve and the branch predictor.
//
// The PC and prediction types are type parameters so this file stands alone;
// instances pass C::pc_t / C::bp_t.
//
// Signal groups:
//   res_*      resolved instruction from execute (execute -> bresolve)
//   redirect_* one-cycle fetch redirect          (bresolve -> fetch)
//   upd_*      predictor training update          (bresolve -> predictor)
//   stat_*     branch / mispredict counters       (bresolve -> observers)
//
// Handshake rules (res_* and upd_*): a transfer happens on a rising clk edge
// where valid and ready are both 1. Nothing else has any effect. ready never
// depends combinationally on valid. The producer holds valid and the payload
// stable until the transfer.
//
// Modports:
//   slave  -- bresolve's view
//   master -- the environment's view (execute + fetch + predictor)
// -----------------------------------------------------------------------------
interface bresolve_if #(
  parameter type pc_t = logic [31:0],
  parameter type bp_t = logic [32:0]
);
  logic        res_valid;
  logic        res_ready;
  pc_t         res_pc;
  bp_t         res_pred;
  logic        res_is_branch;
  logic        res_taken;
  pc_t         res_target;

  logic        redirect_valid;
  pc_t         redirect_pc;

  logic        upd_valid;
  logic        upd_ready;
  pc_t         upd_pc;
  logic        upd_taken;
  pc_t         upd_target;

  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;

  modport slave (
    input  res_valid, res_pc, res_pred, res_is_branch, res_taken, res_target,
    input  upd_ready,
    output res_ready,
    output redirect_valid, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    output stat_branches, stat_mispred
  );

  modport master (
    output res_valid, res_pc, res_pred, res_is_branch, res_taken, res_target,
    output upd_ready,
    input  res_ready,
    input  redirect_valid, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    input  stat_branches, stat_mispred
  );
endinterface

// File: rtl/bresolve.sv
// -----------------------------------------------------------------------------
// bresolve -- branch resolution unit.
//
// Compares each resolved instruction's real next PC with the prediction fetch
// used. On a mismatch it pulses a registered fetch redirect and spends one
// FLUSH cycle refusing wrong-path results. Branches and mispredicted
// instructions are queued as predictor training updates in a small FIFO.
// Branch and mispredict counts are kept in saturating counters.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst          in   asynchronous, active-high reset
//   bus          slave modport of bresolve_if (res_*, redirect_*, upd_*, stat_*)
//   dbg_state_o  out  current FSM state (IDLE / FLUSH)
//
// Parameter:
//   UQ_DEPTH     update queue depth, a power of two from 2 to 16
// -----------------------------------------------------------------------------
package C;
  typedef logic [31:0] pc_t;

  typedef struct packed {
    pc_t  pcnext;
    logic taken;
  } bp_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bres_state_e;

  typedef struct packed {
    pc_t  pc;
    logic taken;
    pc_t  target;
  } upd_entry_t;
endpackage

module bresolve
  import C::*;
#(
  parameter int UQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  bresolve_if.slave   bus,
  output bres_state_e dbg_state_o
);

  localparam int AW = $clog2(UQ_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  bres_state_e state_q, state_d;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  upd_entry_t  mem_q [UQ_DEPTH];

  logic        redirect_valid_q, redirect_valid_d;
  pc_t         redirect_pc_q, redirect_pc_d;

  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // ---------------------------------------------------------------------------
  // Resolution datapath
  // ---------------------------------------------------------------------------
  bp_t        pred;
  logic       taken_eff;
  pc_t        actual_next;
  logic       mispredict;
  logic       q_empty;
  logic       q_full;
  logic       res_ready;
  logic       accept;
  logic       push;
  logic       pop;
  upd_entry_t push_entry;

  assign pred = bus.res_pred;

  always_comb begin
    // Only a taken control-flow instruction leaves the sequential path.
    taken_eff   = bus.res_taken & bus.res_is_branch;
    actual_next = taken_eff ? bus.res_target : (bus.res_pc + pc_t'(32'd4));
    mispredict  = (actual_next != pred.pcnext) | (pred.taken != taken_eff);
  end

  always_comb begin
    q_empty = (wr_ptr_q == rd_ptr_q);
    q_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  // ready is a function of registered state and rst only, so there is no
  // path from res_valid. rst gates it so nothing is accepted during reset.
  assign res_ready  = ~rst & (state_q == ST_IDLE) & ~q_full;
  assign accept     = bus.res_valid & res_ready;
  assign push       = accept & (bus.res_is_branch | mispredict);
  assign pop        = ~q_empty & bus.upd_ready;
  assign push_entry = '{pc: bus.res_pc, taken: bus.res_taken, target: bus.res_target};

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && mispredict) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Queue, redirect and counter next state
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d         = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d         = rd_ptr_q + (AW+1)'(pop);

    redirect_valid_d = accept & mispredict;
    redirect_pc_d    = redirect_pc_q;
    if (accept && mispredict) redirect_pc_d = actual_next;

    // Counters stop at all-ones instead of wrapping.
    stat_branches_d  = stat_branches_q;
    if (accept && bus.res_is_branch && (stat_branches_q != 32'hFFFF_FFFF))
      stat_branches_d = stat_branches_q + 32'd1;

    stat_mispred_d   = stat_mispred_q;
    if (accept && mispredict && (stat_mispred_q != 32'hFFFF_FFFF))
      stat_mispred_d = stat_mispred_q + 32'd1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stat_branches_q  <= '0;
      stat_mispred_q   <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      stat_branches_q  <= stat_branches_d;
      stat_mispred_q   <= stat_mispred_d;
    end
  end

  // Storage needs no reset: resetting the pointers empties the queue.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.res_ready      = res_ready;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.upd_valid      = ~q_empty;
  assign bus.upd_pc         = mem_q[rd_ptr_q[AW-1:0]].pc;
  assign bus.upd_taken      = mem_q[rd_ptr_q[AW-1:0]].taken;
  assign bus.upd_target     = mem_q[rd_ptr_q[AW-1:0]].target;
  assign bus.stat_branches  = stat_branches_q;
  assign bus.stat_mispred   = stat_mispred_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_bresolve.sv
// -----------------------------------------------------------------------------
// tb_bresolve -- self-checking bench for bresolve.
//
// Inputs change at the falling edge, and outputs are read there too. The
// reference model steps once per rising edge. It keeps the expected update
// queue, the expected redirect and the expected counters.
// -----------------------------------------------------------------------------
module tb_bresolve;
  import C::*;

  localparam int UQ_DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bres_state_e dbg_state;
  bresolve_if #(.pc_t(C::pc_t), .bp_t(C::bp_t)) bif ();

  bresolve #(.UQ_DEPTH(UQ_DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bif),
    .dbg_state_o (dbg_state)
  );

  // scoreboard / reference model
  int          checks = 0;
  int          errors = 0;
  logic [64:0] exp_q[$];
  bit          m_flush;
  bit          m_redir;
  logic [31:0] m_redir_pc;
  logic [31:0] m_br;
  logic [31:0] m_mp;

  function automatic bit exp_ready();
    return (rst !== 1'b1) && !m_flush && (exp_q.size() < UQ_DEPTH);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_flush    = 1'b0;
    m_redir    = 1'b0;
    m_redir_pc = '0;
    m_br       = '0;
    m_mp       = '0;
  endtask

  // driver tasks
  task automatic drive(input bit v, input logic [31:0] pc, input bit isb,
                       input bit tk, input logic [31:0] tgt,
                       input logic [31:0] ppc, input bit ptk);
    bif.res_valid         = v;
    bif.res_pc            = pc;
    bif.res_is_branch     = isb;
    bif.res_taken         = tk;
    bif.res_target        = tgt;
    bif.res_pred.pcnext   = ppc;
    bif.res_pred.taken    = ptk;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // Advance one clock. The model works out the result of this edge from the
  // rules, using the inputs as they stand now.
  task automatic step();
    bit          acc, teff, mis, do_pop, isb;
    logic [31:0] an, pc, tgt;
    bit          tk;
    acc    = bif.res_valid && exp_ready();
    isb    = bif.res_is_branch;
    tk     = bif.res_taken;
    pc     = bif.res_pc;
    tgt    = bif.res_target;
    teff   = tk && isb;
    an     = teff ? tgt : pc + 32'd4;
    mis    = acc && ((an != bif.res_pred.pcnext) || (bif.res_pred.taken != teff));
    do_pop = (exp_q.size() > 0) && (bif.upd_ready === 1'b1);
    @(posedge clk);
    @(negedge clk);
    if (rst === 1'b1) begin
      model_reset();
      return;
    end
    if (do_pop) void'(exp_q.pop_front());
    if (acc && (isb || mis)) exp_q.push_back({pc, tk, tgt});
    m_flush = mis;
    m_redir = mis;
    if (mis) m_redir_pc = an;
    if (acc && isb && m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
    if (mis && m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle();
    bif.upd_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bif.res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0b want 0", bif.res_ready); end
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL reset_upd_valid: got %0b want 0", bif.upd_valid); end
    checks++; if (bif.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %0b want 0", bif.redirect_valid); end
    checks++; if (bif.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", bif.redirect_pc); end
    checks++; if (bif.stat_branches !== 32'h0) begin errors++; $display("FAIL reset_stat_branches: got %h want 0", bif.stat_branches); end
    checks++; if (bif.stat_mispred !== 32'h0) begin errors++; $display("FAIL reset_stat_mispred: got %h want 0", bif.stat_mispred); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
    rst = 1'b0;
    #1;
    checks++; if (bif.res_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %0b want 1", bif.res_ready); end
  endtask

  task automatic test_nonbranch();
    bif.upd_ready = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h104, 1'b0);
    step();
    // pc+4 wraps to 0 at the top of the address space
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0000_0800, 32'h0, 1'b0);
    step();
    idle();
    checks++; if (bif.redirect_valid !== 1'b0) begin errors++; $display("FAIL nonbranch_redirect: got %0b want 0", bif.redirect_valid); end
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL nonbranch_push: got %0b want 0", bif.upd_valid); end
    checks++; if (bif.stat_branches !== 32'h0) begin errors++; $display("FAIL nonbranch_stat_br: got %h want 0", bif.stat_branches); end
    checks++; if (bif.stat_mispred !== 32'h0) begin errors++; $display("FAIL nonbranch_stat_mp: got %h want 0", bif.stat_mispred); end
    checks++; if (bif.res_ready !== 1'b1) begin errors++; $display("FAIL nonbranch_ready: got %0b want 1", bif.res_ready); end
  endtask

  task automatic test_mispredict();
    bif.upd_ready = 1'b0;
    drive(1'b1, 32'h200, 1'b1, 1'b1, 32'h400, 32'h204, 1'b0);
    step();
    // A wrong-path branch arrives in the FLUSH cycle and must be ignored.
    drive(1'b1, 32'h204, 1'b1, 1'b0, 32'h900, 32'h208, 1'b0);
    checks++; if (bif.redirect_valid !== 1'b1) begin errors++; $display("FAIL mp_redirect_valid: got %0b want 1", bif.redirect_valid); end
    checks++; if (bif.redirect_pc !== 32'h400) begin errors++; $display("FAIL mp_redirect_pc: got %h want 00000400", bif.redirect_pc); end
    checks++; if (bif.res_ready !== 1'b0) begin errors++; $display("FAIL mp_flush_ready: got %0b want 0", bif.res_ready); end
    checks++; if (dbg_state !== ST_FLUSH) begin errors++; $display("FAIL mp_state: got %0d want FLUSH", dbg_state); end
    checks++; if ({bif.upd_valid, bif.upd_pc, bif.upd_taken, bif.upd_target} !== {1'b1, 32'h200, 1'b1, 32'h400})
      begin errors++; $display("FAIL mp_update: got v=%0b %h %0b %h want v=1 00000200 1 00000400", bif.upd_valid, bif.upd_pc, bif.upd_taken, bif.upd_target); end
    checks++; if (bif.stat_mispred !== 32'd1) begin errors++; $display("FAIL mp_stat_mp: got %0d want 1", bif.stat_mispred); end
    checks++; if (bif.stat_branches !== 32'd1) begin errors++; $display("FAIL mp_stat_br: got %0d want 1", bif.stat_branches); end
    step();
    idle();
    checks++; if (bif.redirect_valid !== 1'b0) begin errors++; $display("FAIL mp_pulse_len: got %0b want 0", bif.redirect_valid); end
    checks++; if (bif.res_ready !== 1'b1) begin errors++; $display("FAIL mp_ready_back: got %0b want 1", bif.res_ready); end
    checks++; if (bif.stat_branches !== 32'd1) begin errors++; $display("FAIL mp_wrongpath_ignored: got %0d want 1", bif.stat_branches); end
    bif.upd_ready = 1'b1;
    step();
    bif.upd_ready = 1'b0;
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL mp_drain: got %0b want 0", bif.upd_valid); end
  endtask

  task automatic test_full();
    logic [31:0] pc, tgt;
    bit tk;
    bif.upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pc  = 32'h1000 + 32'(16 * i);
      tgt = 32'h2000 + 32'(16 * i);
      tk  = i[0];
      drive(1'b1, pc, 1'b1, tk, tgt, tk ? tgt : pc + 32'd4, tk);
      step();
    end
    idle();
    checks++; if (bif.res_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", bif.res_ready); end
    checks++; if (bif.redirect_valid !== 1'b0) begin errors++; $display("FAIL full_no_redirect: got %0b want 0", bif.redirect_valid); end
    bif.upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (bif.upd_valid !== 1'b1 || bif.upd_pc !== 32'h1000 + 32'(16 * i))
        begin errors++; $display("FAIL full_drain_order%0d: got v=%0b pc=%h want v=1 pc=%h", i, bif.upd_valid, bif.upd_pc, 32'h1000 + 32'(16 * i)); end
      checks++; if (bif.res_ready !== (i > 0))
        begin errors++; $display("FAIL full_drain_ready%0d: got %0b want %0b", i, bif.res_ready, (i > 0)); end
      step();
    end
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %0b want 0", bif.upd_valid); end
    bif.upd_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    bif.upd_ready = 1'b0;
    drive(1'b1, 32'h3000, 1'b1, 1'b0, 32'h5000, 32'h3004, 1'b0);
    step();
    drive(1'b1, 32'h3010, 1'b1, 1'b1, 32'h5010, 32'h5010, 1'b1);
    step();
    bif.upd_ready = 1'b1;
    drive(1'b1, 32'h3020, 1'b1, 1'b1, 32'h5020, 32'h5020, 1'b1);
    checks++; if (bif.upd_pc !== 32'h3000) begin errors++; $display("FAIL pp_head0: got %h want 00003000", bif.upd_pc); end
    step();
    idle();
    checks++; if (bif.upd_pc !== 32'h3010 || bif.upd_target !== 32'h5010)
      begin errors++; $display("FAIL pp_head1: got %h/%h want 00003010/00005010", bif.upd_pc, bif.upd_target); end
    checks++; if (bif.res_ready !== 1'b1) begin errors++; $display("FAIL pp_ready: got %0b want 1", bif.res_ready); end
    step();
    checks++; if (bif.upd_valid !== 1'b1 || bif.upd_pc !== 32'h3020)
      begin errors++; $display("FAIL pp_head2: got v=%0b %h want v=1 00003020", bif.upd_valid, bif.upd_pc); end
    step();
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %0b want 0", bif.upd_valid); end
    bif.upd_ready = 1'b0;
  endtask

  task automatic test_saturation();
    force dut.stat_mispred_q = 32'hFFFF_FFFE;
    #1;
    release dut.stat_mispred_q;
    m_mp = 32'hFFFF_FFFE;
    checks++; if (bif.stat_mispred !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sat_preload: got %h want fffffffe", bif.stat_mispred); end
    bif.upd_ready = 1'b1;
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h600, 1'b0);
    step();
    idle();
    checks++; if (bif.stat_mispred !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_first: got %h want ffffffff", bif.stat_mispred); end
    step();
    drive(1'b1, 32'h700, 1'b1, 1'b0, 32'h900, 32'h900, 1'b1);
    step();
    idle();
    checks++; if (bif.stat_mispred !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_hold: got %h want ffffffff", bif.stat_mispred); end
    checks++; if (bif.stat_branches !== m_br) begin errors++; $display("FAIL sat_branches: got %h want %h", bif.stat_branches, m_br); end
    repeat (3) step();
    bif.upd_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bif.upd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h6000 + 32'(8 * i), 1'b1, 1'b0, 32'h7000, 32'h6004 + 32'(8 * i), 1'b0);
      step();
    end
    drive(1'b1, 32'h4000, 1'b1, 1'b1, 32'h4800, 32'h4004, 1'b0);
    checks++; if (bif.upd_valid !== 1'b1 || bif.res_ready !== 1'b1)
      begin errors++; $display("FAIL rm_setup: got v=%0b rdy=%0b want v=1 rdy=1", bif.upd_valid, bif.res_ready); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL rm_upd_now: got %0b want 0", bif.upd_valid); end
    checks++; if (bif.res_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_now: got %0b want 0", bif.res_ready); end
    step();
    checks++; if (bif.redirect_valid !== 1'b0) begin errors++; $display("FAIL rm_redirect: got %0b want 0", bif.redirect_valid); end
    checks++; if (bif.upd_valid !== 1'b0) begin errors++; $display("FAIL rm_upd: got %0b want 0", bif.upd_valid); end
    checks++; if (bif.stat_mispred !== 32'h0 || bif.stat_branches !== 32'h0)
      begin errors++; $display("FAIL rm_stats: got %h/%h want 0/0", bif.stat_branches, bif.stat_mispred); end
    idle();
    rst = 1'b0;
    #1;
    checks++; if (bif.res_ready !== 1'b1) begin errors++; $display("FAIL rm_ready_back: got %0b want 1", bif.res_ready); end
    step();
    checks++; if (bif.redirect_valid !== 1'b0 || bif.upd_valid !== 1'b0)
      begin errors++; $display("FAIL rm_quiet: got rv=%0b uv=%0b want 0/0", bif.redirect_valid, bif.upd_valid); end
  endtask

  task automatic test_random();
    logic [31:0] pc, tgt, ppc, an;
    bit v, isb, tk, ptk, teff;
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 7);
      isb = $urandom_range(0, 1);
      tk  = $urandom_range(0, 1);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      tgt = $urandom() & 32'hFFFF_FFFC;
      teff = tk && isb;
      an  = teff ? tgt : pc + 32'd4;
      case ($urandom_range(0, 3))
        0, 1:    begin ppc = an;   ptk = teff; end
        2:       begin ppc = an;   ptk = !teff; end
        default: begin ppc = $urandom() & 32'hFFFF_FFFC; ptk = $urandom_range(0, 1); end
      endcase
      drive(v, pc, isb, tk, tgt, ppc, ptk);
      bif.upd_ready = $urandom_range(0, 1);
      checks++; if (bif.res_ready !== exp_ready())
        begin errors++; $display("FAIL rnd_ready@%0d: got %0b want %0b", n, bif.res_ready, exp_ready()); end
      checks++; if (bif.upd_valid !== (exp_q.size() > 0))
        begin errors++; $display("FAIL rnd_upd_valid@%0d: got %0b want %0b", n, bif.upd_valid, (exp_q.size() > 0)); end
      if (exp_q.size() > 0) begin
        checks++; if ({bif.upd_pc, bif.upd_taken, bif.upd_target} !== exp_q[0])
          begin errors++; $display("FAIL rnd_payload@%0d: got %h want %h", n, {bif.upd_pc, bif.upd_taken, bif.upd_target}, exp_q[0]); end
      end
      checks++; if (bif.redirect_valid !== m_redir)
        begin errors++; $display("FAIL rnd_redirect@%0d: got %0b want %0b", n, bif.redirect_valid, m_redir); end
      if (m_redir) begin
        checks++; if (bif.redirect_pc !== m_redir_pc)
          begin errors++; $display("FAIL rnd_redirect_pc@%0d: got %h want %h", n, bif.redirect_pc, m_redir_pc); end
      end
      checks++; if (bif.stat_branches !== m_br || bif.stat_mispred !== m_mp)
        begin errors++; $display("FAIL rnd_stats@%0d: got %0d/%0d want %0d/%0d", n, bif.stat_branches, bif.stat_mispred, m_br, m_mp); end
      step();
    end
    idle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle();
    bif.upd_ready = 1'b0;
    model_reset();
    test_reset();
    test_nonbranch();
    test_mispredict();
    test_full();
    test_push_pop();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
